// File: rtl/spp_loop_pkg.sv
// Shared definitions for the counted-loop sequencer: state encoding,
// completion status codes and the busy-state decode helper.
package spp_loop_pkg;

    // Width of the trip count, iteration index and WAIT timer.
    localparam int CNT_W = 8;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } loop_state_t;

    // Completion status reported from DONE until the next start.
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ABORT   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    // The loop counts as busy while it is testing, issuing or waiting.
    function automatic logic state_is_busy(input loop_state_t s);
        return (s == S_CHECK) || (s == S_ISSUE) || (s == S_WAIT);
    endfunction

endpackage

// File: rtl/loop_sequencer_if.sv
// Decoder/datapath-facing signal bundle of the loop sequencer.
// master: the side that starts loops and acknowledges iterations.
// slave : the sequencer itself.
interface loop_sequencer_if;
    import spp_loop_pkg::*;

    // From the instruction decoder and the loop-body datapath
    logic             start;
    logic [CNT_W-1:0] count_in;
    logic             abort;
    logic             iter_done;

    // From the sequencer
    logic             iter_start;
    logic [CNT_W-1:0] iter_idx;
    logic             busy;
    logic             done;
    logic [1:0]       status;

    modport master (
        output start, count_in, abort, iter_done,
        input  iter_start, iter_idx, busy, done, status
    );

    modport slave (
        input  start, count_in, abort, iter_done,
        output iter_start, iter_idx, busy, done, status
    );

endinterface

// File: rtl/ZeroComparator.sv
// Zero detector used as the loop termination test on the live count.
module ZeroComparator #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    output logic         z_o
);

    assign z_o = (a_i == '0);

endmodule

// File: rtl/loop_sequencer.sv
// Counted-loop controller: loads a trip count, issues one iteration request
// per trip, waits for the datapath acknowledge (bounded by TIMEOUT cycles),
// and reports completion with a one-cycle done pulse and a held status.
// All outputs are decoded from registers only.
module loop_sequencer
    import spp_loop_pkg::*;
#(
    // Max WAIT cycles before giving up on iter_done; 0 disables, range 0..255.
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    loop_sequencer_if.slave bus
);

    // Timer value on the final permitted WAIT cycle.
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMER_LAST = (TIMEOUT == 0) ? CNT_W'(0) : CNT_W'(TIMEOUT - 1);

    loop_state_t      state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] idx_q,    idx_d;
    logic [CNT_W-1:0] timer_q,  timer_d;
    logic [1:0]       status_q, status_d;
    logic             cnt_zero;

    // Termination test on the live count register.
    ZeroComparator #(
        .W (CNT_W)
    ) u_zero_cmp (
        .a_i (cnt_q),
        .z_o (cnt_zero)
    );

    // State and loop registers; reset abandons any loop without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            status_q <= status_d;
        end
    end

    // Next-state and register updates; abort outranks iter_done, which outranks timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        status_d = status_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d    = bus.count_in;
                    idx_d    = '0;
                    status_d = ST_OK;
                    state_d  = S_CHECK;
                end
            end

            S_CHECK: begin
                if (bus.abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else if (cnt_zero) begin
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                timer_d = '0;
                if (bus.abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.abort) begin
                    // Count and index stay frozen; a simultaneous ack is dropped.
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else if (bus.iter_done) begin
                    // Only reached with cnt non-zero, so the decrement never wraps.
                    cnt_d   = cnt_q - CNT_W'(1);
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = S_CHECK;
                end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state and loop registers.
    always_comb begin
        bus.iter_start = (state_q == S_ISSUE);
        bus.busy       = state_is_busy(state_q);
        bus.done       = (state_q == S_DONE);
        bus.iter_idx   = idx_q;
        bus.status     = status_q;
    end

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer: a reactive datapath acknowledges each iteration
// after a chosen latency while a timing model predicts, per cycle, the pulses,
// busy window, done cycle and final status of every loop.
module tb_loop_sequencer;
    import spp_loop_pkg::*;

    localparam int TO   = 4;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic rst_n;

    loop_sequencer_if lif ();

    loop_sequencer #(
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lif)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Expected behaviour of one loop, indexed by cycle after start (cycle 1 = first cycle after the start edge)
    bit         exp_is  [MAXC];
    int         exp_idx [MAXC];
    int         exp_done_cyc;
    logic [1:0] exp_status;
    int         exp_final_idx;
    bit         exp_idx_known;
    int         exp_pulses;

    // Stimulus plan: per-iteration ack latency (WAIT cycles before ack), abort point
    int lat [256];
    int ab_iter;
    int ab_w;
    bit ab_fire;
    bit noise;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Timing model: each iteration costs ISSUE + (lat+1) WAIT cycles + CHECK.
    task automatic build_model(input int n);
        int pos;
        int e;
        bit fin;
        for (int c = 0; c < MAXC; c++) begin
            exp_is[c]  = 1'b0;
            exp_idx[c] = 0;
        end
        pos           = 1;
        fin           = 1'b0;
        exp_pulses    = 0;
        ab_fire       = 1'b0;
        exp_idx_known = 1'b1;
        exp_final_idx = 0;
        for (int i = 0; i < n && !fin; i++) begin
            exp_is[pos + 1]  = 1'b1;
            exp_idx[pos + 1] = i;
            exp_pulses++;
            // last WAIT cycle index reached in this iteration
            e = (lat[i] < TO - 1) ? lat[i] : TO - 1;
            if (i == ab_iter && ab_w <= e) begin
                ab_fire       = 1'b1;
                exp_done_cyc  = pos + 3 + ab_w;
                exp_status    = ST_ABORT;
                exp_final_idx = i;
                fin           = 1'b1;
            end else if (lat[i] <= TO - 1) begin
                pos += 3 + lat[i];
            end else begin
                exp_done_cyc  = pos + 2 + TO;
                exp_status    = ST_TIMEOUT;
                exp_final_idx = i;
                fin           = 1'b1;
            end
        end
        if (!fin) begin
            exp_done_cyc  = pos + 1;
            exp_status    = ST_OK;
            exp_idx_known = 1'b0;
        end
    endtask

    task automatic run(input int n, input string name);
        int ack_cyc;
        int abort_cyc;
        int k;
        int pulses;
        int last_idx;
        build_model(n);
        ack_cyc   = -1;
        abort_cyc = -1;
        k         = 0;
        pulses    = 0;
        last_idx  = -1;
        lif.start     = 1'b1;
        lif.count_in  = 8'(n);
        lif.iter_done = 1'b0;
        lif.abort     = 1'b0;
        step();
        lif.start = 1'b0;
        for (int c = 1; c <= exp_done_cyc + 2; c++) begin
            chk($sformatf("%s c%0d iter_start", name, c), 32'(lif.iter_start), 32'(exp_is[c]));
            chk($sformatf("%s c%0d busy", name, c), 32'(lif.busy), 32'(c < exp_done_cyc));
            chk($sformatf("%s c%0d done", name, c), 32'(lif.done), 32'(c == exp_done_cyc));
            if (lif.iter_start === 1'b1) begin
                pulses++;
                last_idx = int'(lif.iter_idx);
                if (exp_is[c]) chk($sformatf("%s c%0d iter_idx", name, c), 32'(lif.iter_idx), 32'(exp_idx[c]));
                if (k < 256) begin
                    ack_cyc = c + 1 + lat[k];
                    if (k == ab_iter && ab_fire) abort_cyc = c + 1 + ab_w;
                end
                k++;
            end
            if (c == exp_done_cyc) begin
                chk($sformatf("%s status", name), 32'(lif.status), 32'(exp_status));
                if (exp_idx_known) chk($sformatf("%s final iter_idx", name), 32'(lif.iter_idx), 32'(exp_final_idx));
            end
            if (c == exp_done_cyc + 1) chk($sformatf("%s status held", name), 32'(lif.status), 32'(exp_status));

            lif.iter_done = (c == ack_cyc);
            lif.abort     = (c == abort_cyc);
            lif.start     = 1'b0;
            if (noise) begin
                // start while busy or in DONE, ack while in ISSUE: both must be ignored
                if (c <= exp_done_cyc && $urandom_range(0, 3) == 0) begin
                    lif.start    = 1'b1;
                    lif.count_in = 8'($urandom);
                end
                if (lif.iter_start === 1'b1 && $urandom_range(0, 1) == 0) lif.iter_done = 1'b1;
            end
            step();
        end
        lif.start     = 1'b0;
        lif.iter_done = 1'b0;
        lif.abort     = 1'b0;
        chk($sformatf("%s pulse count", name), 32'(pulses), 32'(exp_pulses));
        if (exp_pulses > 0) chk($sformatf("%s last pulse idx", name), 32'(last_idx), 32'(exp_pulses - 1));
    endtask

    initial begin
        rst_n         = 1'b0;
        lif.start     = 1'b0;
        lif.count_in  = '0;
        lif.abort     = 1'b0;
        lif.iter_done = 1'b0;
        noise         = 1'b0;
        ab_iter       = -1;
        ab_w          = 0;
        for (int i = 0; i < 256; i++) lat[i] = 0;

        // Reset state
        repeat (3) step();
        chk("rst iter_start", 32'(lif.iter_start), 32'd0);
        chk("rst busy", 32'(lif.busy), 32'd0);
        chk("rst done", 32'(lif.done), 32'd0);
        chk("rst iter_idx", 32'(lif.iter_idx), 32'd0);
        chk("rst status", 32'(lif.status), 32'(ST_OK));
        rst_n = 1'b1;
        step();

        // iter_done and abort in IDLE do nothing
        lif.iter_done = 1'b1;
        lif.abort     = 1'b1;
        step();
        lif.iter_done = 1'b0;
        lif.abort     = 1'b0;
        step();
        chk("idle busy", 32'(lif.busy), 32'd0);
        chk("idle done", 32'(lif.done), 32'd0);

        // Zero trip count
        run(0, "cnt0");

        // Three iterations, immediate ack
        run(3, "cnt3");

        // Timeout on the first iteration
        lat[0] = 100;
        run(2, "timeout");
        lat[0] = 0;

        // Abort coinciding with ack on the second iteration
        ab_iter = 1;
        ab_w    = 0;
        run(5, "abort");
        ab_iter = -1;

        // Ack on the final permitted WAIT cycle is accepted
        lat[0] = TO - 1;
        lat[1] = TO - 1;
        run(2, "ack_last");
        lat[0] = 0;
        lat[1] = 0;

        // Full 255-trip loop with spurious start / ack activity
        noise = 1'b1;
        run(255, "cnt255");

        // Randomised loops
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(0, 10);
            for (int i = 0; i < 256; i++) lat[i] = $urandom_range(0, 5);
            ab_iter = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : -1;
            ab_w    = $urandom_range(0, 4);
            run(n, $sformatf("rand%0d", r));
        end
        noise   = 1'b0;
        ab_iter = -1;

        // Reset while waiting on the second iteration
        lif.start    = 1'b1;
        lif.count_in = 8'd5;
        step();
        lif.start = 1'b0;
        step();
        chk("mid issue", 32'(lif.iter_start), 32'd1);
        step();
        lif.iter_done = 1'b1;
        step();
        lif.iter_done = 1'b0;
        step();
        step();
        chk("mid busy", 32'(lif.busy), 32'd1);
        chk("mid iter_idx", 32'(lif.iter_idx), 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst iter_start", 32'(lif.iter_start), 32'd0);
        chk("midrst busy", 32'(lif.busy), 32'd0);
        chk("midrst done", 32'(lif.done), 32'd0);
        chk("midrst iter_idx", 32'(lif.iter_idx), 32'd0);
        chk("midrst status", 32'(lif.status), 32'(ST_OK));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("postrst c%0d done", i), 32'(lif.done), 32'd0);
            chk($sformatf("postrst c%0d busy", i), 32'(lif.busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
